// File: rtl/priority_encoder_8to3_if.sv
`default_nettype none
// ============================================================================
// Module      : priority_encoder_8to3_if
// Description : Bus bundle for the 8-to-3 priority encoder. The consumer side
//               (master) drives group enable, requests and acknowledge. The
//               encoder (slave) returns the presented code, its valid flag and
//               the pending-request state.
// Revision    : 1.0 - initial release
// ============================================================================
interface priority_encoder_8to3_if;
  logic [2:0] g;      // group enable, active pattern 3'b100
  logic [7:0] req;    // request lines, bit 7 highest priority
  logic       ack;    // consumer acknowledge of the presented code
  logic [2:0] x;      // presented code
  logic       valid;  // x carries a pending request
  logic [7:0] pend;   // pending-request register
  logic       any;    // at least one request pending

  modport master (
    output g,
    output req,
    output ack,
    input  x,
    input  valid,
    input  pend,
    input  any
  );

  modport slave (
    input  g,
    input  req,
    input  ack,
    output x,
    output valid,
    output pend,
    output any
  );
endinterface
`default_nettype wire

// File: rtl/priority_encoder_8to3.sv
`default_nettype none
// ============================================================================
// Module      : priority_encoder_8to3
// Description : Registered 8-to-3 priority encoder with a pending-request
//               register. Requests are latched while the group enable is
//               active, then presented one at a time (highest index first)
//               and retired by the consumer's acknowledge. A presented code
//               is never preempted; acknowledged codes are replaced by the
//               next pending one without a bubble cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module priority_encoder_8to3 (
  input  wire logic               clk,
  input  wire logic               rst,
  priority_encoder_8to3_if.slave  bus
);

  // Encoder chip-enable pattern: G1 high, G2A low, G2B low.
  localparam logic [2:0] C_G_ENABLE = 3'b100;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Index of the most significant set bit; returns 0 for an all-zero vector,
  // callers only use the result when the vector is known to be non-zero.
  function automatic logic [2:0] f_msb_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_x;
  logic [2:0] w_x_next;
  logic [7:0] r_pend;
  logic [7:0] w_pend_next;

  logic       w_en;
  logic [7:0] w_sample;
  logic [7:0] w_onehot_x;
  logic [7:0] w_clr;
  logic [7:0] w_remaining;
  logic       w_valid;
  logic       w_take;

  // Outputs come straight from registers; "any" is a reduction of pend only.
  assign w_valid   = (r_state == ST_BUSY);
  assign bus.x     = r_x;
  assign bus.valid = w_valid;
  assign bus.pend  = r_pend;
  assign bus.any   = |r_pend;

  // Request sampling and retirement masks. Requests seen while disabled are
  // dropped, not held for later. An acknowledge only counts while a code is
  // being presented.
  assign w_en        = (bus.g == C_G_ENABLE);
  assign w_sample    = w_en ? bus.req : 8'h00;
  assign w_onehot_x  = 8'h01 << r_x;
  assign w_take      = w_valid && bus.ack;
  assign w_clr       = w_take ? w_onehot_x : 8'h00;
  // Set is ORed in after the clear so a same-cycle re-request survives.
  assign w_pend_next = (r_pend & ~w_clr) | w_sample;
  // What is left to serve once the presented code is retired; selection is
  // based on the registered pend only, so this cycle's req is not eligible.
  assign w_remaining = r_pend & ~w_onehot_x;

  // State, code and pending register update; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_x     <= 3'd0;
      r_pend  <= 8'h00;
    end else begin
      r_state <= w_state_next;
      r_x     <= w_x_next;
      r_pend  <= w_pend_next;
    end
  end

  // Next-state and next-code selection.
  always_comb begin
    w_state_next = r_state;
    w_x_next     = r_x;
    case (r_state)
      ST_IDLE: begin
        if (r_pend != 8'h00) begin
          w_x_next     = f_msb_index(r_pend);
          w_state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Hold the presented code until acknowledged, regardless of any
        // higher-priority arrivals.
        if (bus.ack) begin
          if (w_remaining != 8'h00) begin
            w_x_next = f_msb_index(w_remaining);
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_priority_encoder_8to3.sv
`default_nettype none
// ============================================================================
// Module      : tb_priority_encoder_8to3
// Description : Directed bench for priority_encoder_8to3. Stimulus pushes the
//               expected sequence of acknowledged codes into a queue; a
//               monitor pops and compares on every accepted transfer.
//               Register/flag expectations are checked inline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_encoder_8to3;

  logic clk;
  logic rst;

  priority_encoder_8to3_if bus ();

  priority_encoder_8to3 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec;
  int n_err;
  logic [2:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance past the next rising edge; inputs change 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every transfer the DUT completes (valid && ack) consumes one
  // expected code from the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.valid && bus.ack) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard: unexpected code x=%0d at %0t", bus.x, $time);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if (bus.x !== e) begin
          n_err++;
          $display("FAIL scoreboard: got x=%0d, expected x=%0d at %0t", bus.x, e, $time);
        end
      end
    end
  end

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b1;
    bus.g   = 3'b000;
    bus.req = 8'h00;
    bus.ack = 1'b0;

    // Reset state
    #12;
    check("reset_pend",  bus.pend,        8'h00);
    check("reset_valid", {7'd0, bus.valid}, 8'h00);
    check("reset_x",     {5'd0, bus.x},   8'h00);
    check("reset_any",   {7'd0, bus.any}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Single request, latency and retirement
    tick();
    bus.g   = 3'b100;
    bus.req = 8'h08;
    tick();
    bus.req = 8'h00;
    check("single_pend",  bus.pend,          8'h08);
    check("single_valid0", {7'd0, bus.valid}, 8'h00);
    exp_q.push_back(3'd3);
    tick();
    check("single_valid1", {7'd0, bus.valid}, 8'h01);
    check("single_x",      {5'd0, bus.x},     8'h03);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("single_done_valid", {7'd0, bus.valid}, 8'h00);
    check("single_done_pend",  bus.pend,          8'h00);

    // Priority and back-to-back drain; the first-cycle ack is ignored
    bus.req = 8'hA5;
    bus.ack = 1'b1;
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd5);
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd0);
    tick();
    bus.req = 8'h00;
    check("drain_pend_loaded", bus.pend, 8'hA5);
    tick();
    check("drain_first_x", {5'd0, bus.x}, 8'h07);
    tick();
    check("drain_second_x", {5'd0, bus.x}, 8'h05);
    check("drain_pend_mid", bus.pend, 8'h25);
    for (int i = 0; i < 10 && bus.valid; i++) tick();
    bus.ack = 1'b0;
    check("drain_end_valid", {7'd0, bus.valid}, 8'h00);
    check("drain_end_pend",  bus.pend,          8'h00);

    // No preemption
    bus.req = 8'h04;
    tick();
    bus.req = 8'h00;
    tick();
    check("nopre_x2", {5'd0, bus.x}, 8'h02);
    bus.req = 8'h80;
    tick();
    bus.req = 8'h00;
    check("nopre_hold_x", {5'd0, bus.x}, 8'h02);
    check("nopre_pend",   bus.pend,      8'h84);
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd7);
    bus.ack = 1'b1;
    tick();
    check("nopre_next_x", {5'd0, bus.x}, 8'h07);
    tick();
    bus.ack = 1'b0;
    check("nopre_idle", {7'd0, bus.valid}, 8'h00);

    // Enable gating
    bus.req = 8'hFF;
    bus.g = 3'b011; tick();
    bus.g = 3'b101; tick();
    bus.g = 3'b010; tick();
    check("gate_pend",  bus.pend,          8'h00);
    check("gate_valid", {7'd0, bus.valid}, 8'h00);
    bus.g = 3'b100;
    tick();
    bus.g   = 3'b000;
    bus.req = 8'h00;
    check("gate_pend_full", bus.pend, 8'hFF);
    // Disabled group must not stop the already pending bits being served
    for (int i = 7; i >= 0; i--) exp_q.push_back(3'(i));
    bus.ack = 1'b1;
    tick();
    for (int i = 0; i < 20 && (bus.valid || bus.pend != 8'h00); i++) tick();
    bus.ack = 1'b0;
    check("gate_drained", bus.pend, 8'h00);
    bus.g = 3'b100;

    // Set wins over clear on the same bit
    bus.req = 8'h10;
    tick();
    bus.req = 8'h00;
    tick();
    check("setwin_x4", {5'd0, bus.x}, 8'h04);
    exp_q.push_back(3'd4);
    bus.ack = 1'b1;
    bus.req = 8'h10;
    tick();
    bus.ack = 1'b0;
    bus.req = 8'h00;
    check("setwin_pend", bus.pend, 8'h10);
    tick();
    check("setwin_valid_again", {7'd0, bus.valid}, 8'h01);
    check("setwin_x_again",     {5'd0, bus.x},     8'h04);
    exp_q.push_back(3'd4);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("setwin_cleared", bus.pend, 8'h00);

    // Asynchronous reset mid-operation
    bus.req = 8'h3C;
    tick();
    bus.req = 8'h00;
    tick();
    check("rstmid_pend",  bus.pend,          8'h3C);
    check("rstmid_valid", {7'd0, bus.valid}, 8'h01);
    check("rstmid_x",     {5'd0, bus.x},     8'h05);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_pend0",  bus.pend,          8'h00);
    check("rstmid_valid0", {7'd0, bus.valid}, 8'h00);
    check("rstmid_x0",     {5'd0, bus.x},     8'h00);
    check("rstmid_any0",   {7'd0, bus.any},   8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Index 0 after reset is a real code
    tick();
    bus.req = 8'h01;
    tick();
    bus.req = 8'h00;
    check("zero_any", {7'd0, bus.any}, 8'h01);
    tick();
    check("zero_valid", {7'd0, bus.valid}, 8'h01);
    check("zero_x",     {5'd0, bus.x},     8'h00);
    exp_q.push_back(3'd0);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("zero_done", {7'd0, bus.valid}, 8'h00);

    tick();
    check("scoreboard_empty", 8'(exp_q.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
